// File: rtl/aespp_pkg.sv
// Shared types and widths for the aespp request scheduler.
package aespp_pkg;
    localparam int CNT_W = 5;  // up to 16 words per chain, plus headroom
    localparam int ID_W  = 2;  // up to 4 requesters

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_RESP
    } state_t;
endpackage

// File: rtl/aespp_rr_arb.sv
// Combinational round-robin picker: first active request after `last`, wrapping.
module aespp_rr_arb
    import aespp_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offset 1 first so the last winner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!any && ((int'(last) + i) % NREQ == j) && req[j]) begin
                    any    = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = ID_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/aespp_sched.sv
// Shares one aespp conditioner among NREQ requesters, one chain at a time.
// Optional per-requester grant counters: define AESPP_SCHED_STATS_EN.
module aespp_sched
    import aespp_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int STAT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [128*NREQ-1:0]    i_req_dat,
    input  logic [4*NREQ-1:0]      i_req_blocks,
    output logic [NREQ-1:0]        o_req_pop,
    output logic                   o_core_valid,
    output logic [127:0]           o_core_dat,
    output logic [3:0]             o_core_blocks,
    input  logic                   i_core_consumed,
    input  logic                   i_core_valid,
    input  logic [127:0]           i_core_dat,
    output logic                   o_core_read,
    output logic                   o_rsp_valid,
    output logic [127:0]           o_rsp_dat,
    output logic [ID_W-1:0]        o_rsp_id,
    input  logic                   i_rsp_ready,
`ifdef AESPP_SCHED_STATS_EN
    output logic [STAT_W*NREQ-1:0] o_grant_cnt,
`endif
    output logic                   o_busy
);
    state_t           state;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  last_grant;
    logic [3:0]       blocks;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic [3:0]       arb_blocks;
    logic             cur_valid;
    logic [127:0]     cur_dat;
    logic             take;
    logic             last_word;

    aespp_rr_arb #(.NREQ(NREQ)) u_arb (
        .req  (i_req_valid),
        .last (last_grant),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        arb_blocks = '0;
        cur_valid  = 1'b0;
        cur_dat    = '0;
        for (int r = 0; r < NREQ; r++) begin
            arb_blocks |= {4{arb_gnt[r]}} & i_req_blocks[4*r +: 4];
            if (grant == ID_W'(r)) begin
                cur_valid = i_req_valid[r];
                cur_dat   = i_req_dat[128*r +: 128];
            end
        end
    end

    // Everything toward the core is gated by FEED, so WAIT/RESP can never start a chain.
    assign o_core_valid  = (state == ST_FEED) && cur_valid;
    assign o_core_dat    = (state == ST_FEED) ? cur_dat : '0;
    assign o_core_blocks = (state == ST_FEED) ? blocks : '0;
    assign take          = o_core_valid && i_core_consumed;
    assign last_word     = take && (cnt == CNT_W'(blocks));

    always_comb begin
        o_req_pop = '0;
        for (int r = 0; r < NREQ; r++)
            o_req_pop[r] = take && (grant == ID_W'(r));
    end

    // Response side depends only on state and core outputs, never on i_req_*.
    assign o_rsp_valid = (state == ST_RESP);
    assign o_rsp_dat   = o_rsp_valid ? i_core_dat : '0;
    assign o_rsp_id    = o_rsp_valid ? grant : '0;
    assign o_core_read = o_rsp_valid && i_rsp_ready;
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NREQ - 1);
            blocks     <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (arb_any) begin
                    grant  <= arb_idx;
                    blocks <= arb_blocks;
                    cnt    <= '0;
                    state  <= ST_FEED;
                end
                ST_FEED: begin
                    if (last_word) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else if (take) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: if (i_core_valid) state <= ST_RESP;
                ST_RESP: if (i_rsp_ready) begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AESPP_SCHED_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] grant_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant_cnt <= '0;
        end else if (o_core_read) begin
            for (int r = 0; r < NREQ; r++)
                if (grant == ID_W'(r) && !(&grant_cnt[r]))
                    grant_cnt[r] <= grant_cnt[r] + STAT_W'(1);
        end
    end

    assign o_grant_cnt = grant_cnt;
`endif
endmodule
